fifo_stream_reader: RTL

Read-side controller for the team's dual-port FIFO RAM. It pops words through the FIFO read port (read enable, registered data out, empty flag) and presents them on a valid/ready stream to a downstream consumer. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so throughput is one word per cycle with no drops or duplicates. The block sits in the FIFO's read clock domain.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/stream_skid_buf.sv | 71 +++++++
 rtl/fifo_stream_reader.sv | 62 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream path.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH = 16;
   localparam int unsigned FIFO_DEPTH = 512;
   localparam int unsigned ADDR       = $clog2(FIFO_DEPTH);
   localparam int unsigned SKID_DEPTH = 2;

   typedef logic [1:0] level_t;

   // Buffer fill after this edge: stored words plus the word landing now, minus the one leaving.
   function automatic logic [2:0] fill_after(input level_t level, input logic inflight,
                                             input logic pop);
      return {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: absorbs the FIFO read latency and presents a valid/ready stream.
module stream_skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output level_t           level
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   level_t           level_q, level_d;
   logic             pop;

   assign out_valid = (level_q != 2'd0);
   assign out_data  = head_q;
   assign level     = level_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      case ({in_valid, pop})
         2'b10: begin
            // A push into a full buffer cannot occur when the read gating is correct.
            if (level_q != 2'(SKID_DEPTH)) begin
               if (level_q == 2'd0) begin
                  head_d = in_data;
               end else begin
                  tail_d = in_data;
               end
               level_d = level_q + 2'd1;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            level_d = level_q - 2'd1;
         end
         2'b11: begin
            if (level_q == 2'd1) begin
               head_d = in_data;
            end else begin
               head_d = tail_q;
               tail_d = in_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-port controller: gates read enables against skid space and counts delivered words.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_ren,
   input  logic [FIFO_WIDTH-1:0] fifo_dout,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   logic                 inflight_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   level_t               level;
   logic                 pop;

   assign pop      = m_valid & m_ready;
   assign word_cnt = cnt_q;

   // Only issue a read if the word will have a slot when it lands next cycle.
   always_comb begin
      fifo_ren = 1'b0;
      if (!rst && enable && !fifo_empty &&
          (fill_after(level, inflight_q, pop) < 3'(SKID_DEPTH))) begin
         fifo_ren = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= fifo_ren;
         if (pop && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   stream_skid_buf #(
      .WIDTH (FIFO_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight_q),
      .in_data   (fifo_dout),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_data),
      .level     (level)
   );

endmodule
